trace_event_arbiter: RTL

- Shares one trace/log channel among NUM_SRC per-core execution-trace sources in a multi-tile simulation system.
- Each core's trace (valid, pc, insn, r3) is captured in a one-entry slot per source. Slots are drained round-robin into a single registered output with a valid/ready handshake.
- Per-source termination is detected by matching the exit instruction (l.nop 0x1). The block drives an all-terminated flag that the testbench uses to end simulation.

---
 rtl/trace_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/trace_event_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/trace_arb_pkg.sv
// Shared types and helpers for trace_event_arbiter.
// Optional drop counters are enabled by defining TRACE_ARB_STATS_EN.
package trace_arb_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] r3;
    } trace_event_t;

    localparam int          EVT_W    = $bits(trace_event_t);
    localparam logic [31:0] NOP_EXIT = 32'h15000001;

    // Index width that stays legal for a single source.
    function automatic int src_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
// The caller owns the pointer register and advances it after a grant.
module rr_arbiter
    import trace_arb_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = src_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    logic [W:0]   w_sum;
    logic [W-1:0] w_idx;
    logic         w_found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            // Walk indices ptr, ptr+1, ... modulo N without a divider.
            w_sum = {1'b0, ptr} + (W+1)'(k);
            if (w_sum >= (W+1)'(N)) begin
                w_sum = w_sum - (W+1)'(N);
            end
            w_idx = w_sum[W-1:0];
            if (en && !w_found && req[w_idx]) begin
                w_found      = 1'b1;
                gnt[w_idx]   = 1'b1;
                gnt_idx      = w_idx;
            end
        end
    end

endmodule

// File: rtl/trace_event_arbiter.sv
// Funnels NUM_SRC per-core trace streams into one registered valid/ready channel.
// Define TRACE_ARB_STATS_EN to build the saturating per-source drop counters.
module trace_event_arbiter
    import trace_arb_pkg::*;
#(
    parameter  int          NUM_SRC   = 4,
    parameter  logic [31:0] EXIT_INSN = NOP_EXIT,
    localparam int          SRC_W     = src_width(NUM_SRC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC-1:0]    in_valid,
    input  logic [NUM_SRC*32-1:0] in_pc,
    input  logic [NUM_SRC*32-1:0] in_insn,
    input  logic [NUM_SRC*32-1:0] in_r3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SRC_W-1:0]      out_src,
    output logic [31:0]           out_pc,
    output logic [31:0]           out_insn,
    output logic [31:0]           out_r3,
    output logic [NUM_SRC-1:0]    overflow,
    output logic [NUM_SRC-1:0]    term,
    output logic                  all_term,
    output logic [NUM_SRC*16-1:0] drop_cnt
);

    // Handshake: an output event transfers on a clock edge where out_valid and
    // out_ready are both high; while out_valid=1 and out_ready=0 every out_*
    // signal holds. The output register reloads whenever it is empty or draining.

    trace_event_t         r_slot [NUM_SRC];
    logic [NUM_SRC-1:0]   r_full;
    logic [NUM_SRC-1:0]   r_overflow;
    logic [NUM_SRC-1:0]   r_term;
    logic                 r_all_term;
    logic                 r_out_valid;
    logic [SRC_W-1:0]     r_out_src;
    trace_event_t         r_out;
    logic [SRC_W-1:0]     r_ptr;

    trace_event_t         w_in [NUM_SRC];
    logic [NUM_SRC-1:0]   w_cap;
    logic [NUM_SRC-1:0]   w_drop;
    logic [NUM_SRC-1:0]   w_gnt;
    logic [SRC_W-1:0]     w_gnt_idx;
    logic [SRC_W-1:0]     w_ptr_next;
    logic                 w_load;
    logic                 w_any_gnt;

    assign w_load    = !r_out_valid || out_ready;
    assign w_any_gnt = |w_gnt;

    rr_arbiter #(
        .N (NUM_SRC)
    ) u_rr_arbiter (
        .req     (r_full),
        .ptr     (r_ptr),
        .en      (w_load),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_ptr_next = (w_gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : w_gnt_idx + SRC_W'(1);

    // A slot granted this cycle is free again, so a same-cycle retire refills it.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            w_in[i].pc   = in_pc[32*i +: 32];
            w_in[i].insn = in_insn[32*i +: 32];
            w_in[i].r3   = in_r3[32*i +: 32];
            w_cap[i]     = in_valid[i] && (!r_full[i] || w_gnt[i]);
            w_drop[i]    = in_valid[i] && r_full[i] && !w_gnt[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_slot[i] <= '0;
            end
            r_full     <= '0;
            r_overflow <= '0;
            r_term     <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_cap[i]) begin
                    r_slot[i] <= w_in[i];
                end
                r_full[i] <= w_cap[i] || (r_full[i] && !w_gnt[i]);
                if (w_drop[i]) begin
                    r_overflow[i] <= 1'b1;
                end
                if (w_cap[i] && (w_in[i].insn == EXIT_INSN)) begin
                    r_term[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_src   <= '0;
            r_out       <= '0;
            r_ptr       <= '0;
        end else if (w_load) begin
            if (w_any_gnt) begin
                r_out_valid <= 1'b1;
                r_out_src   <= w_gnt_idx;
                r_out       <= r_slot[w_gnt_idx];
                r_ptr       <= w_ptr_next;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Registered so all_term lags the last term bit by exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_all_term <= 1'b0;
        end else begin
            r_all_term <= &r_term;
        end
    end

`ifdef TRACE_ARB_STATS_EN
    logic [15:0] r_drop_cnt [NUM_SRC];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_drop_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_drop[i] && (r_drop_cnt[i] != 16'hFFFF)) begin
                    r_drop_cnt[i] <= r_drop_cnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        drop_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            drop_cnt[16*i +: 16] = r_drop_cnt[i];
        end
    end
`else
    assign drop_cnt = '0;
`endif

    assign out_valid = r_out_valid;
    assign out_src   = r_out_src;
    assign out_pc    = r_out.pc;
    assign out_insn  = r_out.insn;
    assign out_r3    = r_out.r3;
    assign overflow  = r_overflow;
    assign term      = r_term;
    assign all_term  = r_all_term;

endmodule
